// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source result FIFOs feed two CDB registers through a rotating scan.
// Define CDB_DUAL_GRANT_EN to grant both buses; otherwise only bus 0 is granted and bus 1 stays idle.
module cdb_arbiter #(
  parameter int SOURCES = 4,
  parameter int DEPTH   = 2,
  parameter int REG_W   = 6,
  parameter int XLEN    = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic [SOURCES-1:0]       src_valid,
  output logic [SOURCES-1:0]       src_ready,
  input  logic [SOURCES*REG_W-1:0] src_arn,
  input  logic [SOURCES*REG_W-1:0] src_rrn,
  input  logic [SOURCES*XLEN-1:0]  src_result,
  output logic [1:0]               cdb_valid,
  output logic [2*REG_W-1:0]       cdb_arn,
  output logic [2*REG_W-1:0]       cdb_rrn,
  output logic [2*XLEN-1:0]        cdb_result
);

  localparam int SW = (SOURCES > 1) ? $clog2(SOURCES) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 2 * REG_W + XLEN;

  logic [EW-1:0]      mem    [SOURCES][DEPTH];
  logic [PW-1:0]      rd_ptr [SOURCES];
  logic [PW-1:0]      wr_ptr [SOURCES];
  logic [CW-1:0]      count  [SOURCES];
  logic [SW-1:0]      rr_ptr, rr_next;
  logic [SOURCES-1:0] push, pop;
  logic               g0_vld, g1_vld;
  logic [SW-1:0]      g0_idx, g1_idx, last_idx;
  logic [EW-1:0]      head0, head1;

  // Ready looks only at registered occupancy, so a full FIFO refuses input even while it drains.
  always_comb begin
    src_ready = '0;
    push      = '0;
    for (int unsigned i = 0; i < SOURCES; i++) begin
      src_ready[i] = (count[i] != CW'(DEPTH));
      push[i]      = src_valid[i] & src_ready[i] & ~flush;
    end
  end

  always_comb begin : arb
    int unsigned idx;
    idx    = 0;
    g0_vld = 1'b0;
    g1_vld = 1'b0;
    g0_idx = '0;
    g1_idx = '0;
    for (int unsigned k = 0; k < SOURCES; k++) begin
      idx = (int'(rr_ptr) + k) % SOURCES;
      if (count[SW'(idx)] != '0) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0_idx = SW'(idx);
        end
`ifdef CDB_DUAL_GRANT_EN
        else if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_idx = SW'(idx);
        end
`endif
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < SOURCES; i++) begin
      pop[i] = (g0_vld && (g0_idx == SW'(i))) || (g1_vld && (g1_idx == SW'(i)));
    end
    last_idx = g1_vld ? g1_idx : g0_idx;
    if (!g0_vld)
      rr_next = rr_ptr;
    else if (last_idx == SW'(SOURCES - 1))
      rr_next = '0;
    else
      rr_next = last_idx + 1'b1;
    head0 = mem[g0_idx][rd_ptr[g0_idx]];
    head1 = mem[g1_idx][rd_ptr[g1_idx]];
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < SOURCES; i++) begin
      if (push[i])
        mem[i][wr_ptr[i]] <= {src_arn[i*REG_W +: REG_W], src_rrn[i*REG_W +: REG_W],
                              src_result[i*XLEN +: XLEN]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SOURCES; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
      rr_ptr <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < SOURCES; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int unsigned i = 0; i < SOURCES; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !pop[i])
          count[i] <= count[i] + 1'b1;
        else if (!push[i] && pop[i])
          count[i] <= count[i] - 1'b1;
      end
      rr_ptr <= rr_next;
    end
  end

  // Idle buses must carry zero register numbers: forwarding compares arn/rrn without valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cdb_valid  <= '0;
      cdb_arn    <= '0;
      cdb_rrn    <= '0;
      cdb_result <= '0;
    end else if (flush) begin
      cdb_valid  <= '0;
      cdb_arn    <= '0;
      cdb_rrn    <= '0;
      cdb_result <= '0;
    end else begin
      cdb_valid                <= {g1_vld, g0_vld};
      cdb_arn[0 +: REG_W]      <= g0_vld ? head0[EW-1 -: REG_W] : '0;
      cdb_rrn[0 +: REG_W]      <= g0_vld ? head0[XLEN+REG_W-1 -: REG_W] : '0;
      cdb_result[0 +: XLEN]    <= g0_vld ? head0[XLEN-1:0] : '0;
      cdb_arn[REG_W +: REG_W]  <= g1_vld ? head1[EW-1 -: REG_W] : '0;
      cdb_rrn[REG_W +: REG_W]  <= g1_vld ? head1[XLEN+REG_W-1 -: REG_W] : '0;
      cdb_result[XLEN +: XLEN] <= g1_vld ? head1[XLEN-1:0] : '0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based reference model predicts each cycle's bus and ready state.
module tb_cdb_arbiter;

  localparam int S  = 4;
  localparam int D  = 2;
  localparam int RW = 6;
  localparam int XW = 32;
`ifdef CDB_DUAL_GRANT_EN
  localparam int NG = 2;
`else
  localparam int NG = 1;
`endif

  logic            clk, reset_n, flush;
  logic [S-1:0]    src_valid, src_ready;
  logic [S*RW-1:0] src_arn, src_rrn;
  logic [S*XW-1:0] src_result;
  logic [1:0]      cdb_valid;
  logic [2*RW-1:0] cdb_arn, cdb_rrn;
  logic [2*XW-1:0] cdb_result;

  cdb_arbiter #(.SOURCES(S), .DEPTH(D), .REG_W(RW), .XLEN(XW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_arn(src_arn), .src_rrn(src_rrn), .src_result(src_result),
    .cdb_valid(cdb_valid), .cdb_arn(cdb_arn), .cdb_rrn(cdb_rrn), .cdb_result(cdb_result)
  );

  typedef struct packed {
    logic [RW-1:0] arn;
    logic [RW-1:0] rrn;
    logic [XW-1:0] res;
  } ent_t;

  typedef struct packed {
    logic [1:0]      v;
    logic [2*RW-1:0] arn;
    logic [2*RW-1:0] rrn;
    logic [2*XW-1:0] res;
    logic [S-1:0]    rdy;
  } exp_t;

  ent_t mq[S][$];
  ent_t dat[S];
  exp_t expq[$];
  int   rr;
  int   n_tests, n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic rnd_dat();
    for (int i = 0; i < S; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        dat[i].arn = '0;
        dat[i].rrn = '0;
      end else begin
        dat[i].arn = RW'($urandom);
        dat[i].rrn = RW'($urandom);
      end
      dat[i].res = $urandom;
    end
  endtask

  // One clock of stimulus; the model applies the arbitration rules to its queues for the coming edge.
  task automatic cyc(input logic [S-1:0] v, input logic fl);
    exp_t         e;
    ent_t         g;
    int           idx, ng, start;
    logic [S-1:0] rdy_pre;
    @(negedge clk);
    src_valid = v;
    flush     = fl;
    for (int i = 0; i < S; i++) begin
      src_arn[i*RW +: RW]    = dat[i].arn;
      src_rrn[i*RW +: RW]    = dat[i].rrn;
      src_result[i*XW +: XW] = dat[i].res;
      rdy_pre[i]             = (mq[i].size() < D);
    end
    e = '0;
    if (fl) begin
      for (int i = 0; i < S; i++) mq[i].delete();
      rr = 0;
    end else begin
      ng    = 0;
      start = rr;
      for (int k = 0; k < S; k++) begin
        idx = (start + k) % S;
        if (ng < NG && mq[idx].size() > 0) begin
          g = mq[idx].pop_front();
          e.v[ng]             = 1'b1;
          e.arn[ng*RW +: RW]  = g.arn;
          e.rrn[ng*RW +: RW]  = g.rrn;
          e.res[ng*XW +: XW]  = g.res;
          ng++;
          rr = (idx + 1) % S;
        end
      end
      for (int i = 0; i < S; i++)
        if (v[i] && rdy_pre[i]) mq[i].push_back(dat[i]);
    end
    for (int i = 0; i < S; i++) e.rdy[i] = (mq[i].size() < D);
    expq.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"},  64'(cdb_valid),  '0);
    chk({tag, "_arn"},    64'(cdb_arn),    '0);
    chk({tag, "_rrn"},    64'(cdb_rrn),    '0);
    chk({tag, "_result"}, 64'(cdb_result), '0);
    chk({tag, "_ready"},  64'(src_ready),  64'({S{1'b1}}));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("cdb_valid",  64'(cdb_valid),  64'(e.v));
        chk("cdb_arn",    64'(cdb_arn),    64'(e.arn));
        chk("cdb_rrn",    64'(cdb_rrn),    64'(e.rrn));
        chk("cdb_result", cdb_result,      e.res);
        chk("src_ready",  64'(src_ready),  64'(e.rdy));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int spins;
    n_tests = 0; n_fail = 0; rr = 0;
    reset_n = 1'b0; flush = 1'b0; src_valid = '0;
    src_arn = '0; src_rrn = '0; src_result = '0;
    rnd_dat();
    #3;
    chk_reset_outputs("por");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    repeat (5) cyc('0, 1'b0);

    dat[2].arn = RW'(5); dat[2].rrn = RW'(17); dat[2].res = 32'hDEADBEEF;
    cyc(4'b0100, 1'b0);
    repeat (3) cyc('0, 1'b0);

    cyc('0, 1'b1);
    rnd_dat();
    cyc(4'b1111, 1'b0);
    repeat (4) cyc('0, 1'b0);

    rnd_dat();
    cyc(4'b1110, 1'b0);
    for (int c = 0; c < 4; c++) begin
      rnd_dat();
      cyc(4'b1111, 1'b0);
    end
    repeat (8) cyc('0, 1'b0);

    for (int c = 0; c < 2; c++) begin
      rnd_dat();
      cyc(4'b0011, 1'b0);
    end
    rnd_dat();
    cyc(4'b1000, 1'b1);
    repeat (3) cyc('0, 1'b0);

    for (int c = 0; c < 600; c++) begin
      rnd_dat();
      cyc(S'($urandom & $urandom), ($urandom_range(0, 49) == 0));
    end

    @(negedge clk);
    src_valid = '0;
    flush     = 1'b0;
    reset_n   = 1'b0;
    for (int i = 0; i < S; i++) mq[i].delete();
    rr = 0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int c = 0; c < 200; c++) begin
      rnd_dat();
      cyc(S'($urandom), ($urandom_range(0, 63) == 0));
    end
    repeat (10) cyc('0, 1'b0);

    spins = 0;
    while (expq.size() > 0 && spins < 5) begin
      @(posedge clk);
      spins++;
    end
    #2;
    chk("scoreboard_drained", 64'(expq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
